dmem_bytelane: RTL and testbench

Parametrised successor to the single-cycle data memory for the RV32 datapath. Adds byte/halfword/word stores with lane masking and sign- or zero-extended sub-word loads. Misaligned accesses are detected and suppressed. An optional post-reset clear sequencer zeroes the array one word per cycle. Read stays combinational and write stays synchronous, so the block drops into the existing single-cycle core with `ready`/`busy` gating the pipeline during initialisation.

---
 rtl/dmem_bytelane.sv | 114 +++++++++++
 tb/tb_dmem_bytelane.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory: masked sub-word stores, extended sub-word loads,
// misalignment suppression and an optional post-reset zero-fill sequencer.
module dmem_bytelane #(
    parameter int DEPTH      = 64,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        misalign,
    output logic        busy,
    output logic        ready
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state, state_n;
    logic [AW-1:0] cnt;
    logic [AW-1:0] idx;
    logic [31:0]   mem [DEPTH];
    logic          illegal;
    logic          store;
    logic [3:0]    be;
    logic [31:0]   wdl;
    logic [31:0]   word;
    logic [31:0]   shd;
    logic          unused_a;

    assign idx      = a[AW+1:2];
    assign unused_a = ^a[31:AW+2];

    always_comb begin
        illegal = 1'b0;
        be      = 4'b0000;
        wdl     = wd;
        unique case (size)
            2'b00: begin
                be  = 4'b0001 << a[1:0];
                wdl = {4{wd[7:0]}};
            end
            2'b01: begin
                illegal = a[0];
                be      = 4'b0011 << {a[1], 1'b0};
                wdl     = {2{wd[15:0]}};
            end
            2'b10: begin
                illegal = |a[1:0];
                be      = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_n = state;
        if (state == CLEAR && cnt == AW'(DEPTH - 1)) begin
            state_n = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT_CLEAR ? CLEAR : RUN;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_n;
            ready <= (state_n == RUN);
            if (state == CLEAR) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign store = we && ready && !illegal;

    // Array carries no reset; the sequencer owns the write port while clearing.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdl[8*i +: 8];
                end
            end
        end
    end

    assign word = mem[idx];
    assign shd  = word >> {a[1:0], 3'b000};

    always_comb begin
        rd = '0;
        if (ready && !illegal) begin
            unique case (size)
                2'b00:   rd = {{24{~ld_unsigned & shd[7]}}, shd[7:0]};
                2'b01:   rd = {{16{~ld_unsigned & shd[15]}}, shd[15:0]};
                default: rd = word;
            endcase
        end
    end

    assign misalign = ready & illegal;
    assign busy     = (state == CLEAR);

endmodule

// File: tb/tb_dmem_bytelane.sv
// Randomised bench for dmem_bytelane against a byte-array model,
// with directed literal cases pinning the model.
module tb_dmem_bytelane;

    localparam int DEPTH = 64;
    localparam int NB    = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b11;
    logic        ld_unsigned = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        misalign;
    logic        busy;
    logic        ready;

    dmem_bytelane #(.DEPTH(DEPTH), .INIT_CLEAR(1'b1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .we(we),
        .size(size),
        .ld_unsigned(ld_unsigned),
        .a(a),
        .wd(wd),
        .rd(rd),
        .misalign(misalign),
        .busy(busy),
        .ready(ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit [7:0] mb [NB];
    int clr = 0;
    bit m_ready = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    function automatic bit m_illegal(input logic [1:0] sz,
                                     input logic [31:0] ad);
        if (sz == 2'b11) return 1'b1;
        return (ad % (32'd1 << sz)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic u,
                                           input logic [31:0] ad);
        int base;
        int n;
        logic [31:0] v;
        if (!m_ready || m_illegal(sz, ad)) return 32'h0;
        base = int'(ad % NB);
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) v |= 32'(mb[base + i]) << (8 * i);
        if (n < 4 && !u && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 1);
        return v;
    endfunction

    // Entered at posedge+1: drive, check mid-cycle, then advance the model.
    task automatic cyc(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] ad, input logic [31:0] d);
        int base;
        we = w; size = sz; ld_unsigned = u; a = ad; wd = d;
        #3;
        chk("rd", rd, m_load(sz, u, ad));
        chk("misalign", misalign, 32'(m_ready && m_illegal(sz, ad)));
        chk("busy", busy, 32'(!m_ready));
        chk("ready", ready, 32'(m_ready));
        @(posedge clk);
        if (rst_n) begin
            if (m_ready && w && !m_illegal(sz, ad)) begin
                base = int'(ad % NB);
                for (int i = 0; i < (1 << sz); i++) mb[base + i] = d[8*i +: 8];
            end
            if (clr < DEPTH) begin
                for (int i = 0; i < 4; i++) mb[4*clr + i] = 8'h00;
                clr++;
            end
            m_ready = (clr >= DEPTH);
        end
        #1;
    endtask

    task automatic rnd_cyc();
        logic [31:0] ad;
        ad = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
        cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ad, $urandom);
    endtask

    task automatic lit(input string nm, input logic [1:0] sz, input logic u,
                       input logic [31:0] ad, input logic [31:0] exp);
        we = 1'b0; size = sz; ld_unsigned = u; a = ad;
        #2;
        chk(nm, rd, exp);
        cyc(1'b0, sz, u, ad, 32'h0);
    endtask

    task automatic mis(input string nm, input logic [1:0] sz,
                       input logic [31:0] ad);
        we = 1'b1; size = sz; ld_unsigned = 1'b0; a = ad; wd = 32'hFFFF_FFFF;
        #2;
        chk(nm, misalign, 32'h1);
        chk({nm, "_rd"}, rd, 32'h0);
        cyc(1'b1, sz, 1'b0, ad, 32'hFFFF_FFFF);
    endtask

    initial begin
        int n;
        #3;
        chk("rst_ready", ready, 32'h0);
        chk("rst_busy", busy, 32'h1);
        chk("rst_rd", rd, 32'h0);
        chk("rst_misalign", misalign, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 1; i < 30; i++) begin
            if (i == 5) cyc(1'b1, 2'b10, 1'b0, 32'h0, 32'h1234_5678);
            else rnd_cyc();
        end

        rst_n = 1'b0;
        clr = 0;
        m_ready = 1'b0;
        rnd_cyc();
        rnd_cyc();
        chk("midclr_ready", ready, 32'h0);
        rst_n = 1'b1;

        n = 0;
        while (!ready && n < 200) begin
            rnd_cyc();
            n++;
        end
        chk("clear_len", 32'(n), 32'd64);

        lit("drop_store", 2'b10, 1'b0, 32'h00, 32'h0);
        lit("cleared_40", 2'b10, 1'b0, 32'h40, 32'h0);

        cyc(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        lit("word_st", 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        cyc(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00A5);
        lit("byte_st", 2'b10, 1'b0, 32'h10, 32'hDEAD_A5EF);

        cyc(1'b1, 2'b10, 1'b0, 32'h20, 32'h80F0_F27F);
        lit("lb_20", 2'b00, 1'b0, 32'h20, 32'h0000_007F);
        lit("lb_21", 2'b00, 1'b0, 32'h21, 32'hFFFF_FFF2);
        lit("lhu_22", 2'b01, 1'b1, 32'h22, 32'h0000_80F0);
        lit("lh_22", 2'b01, 1'b0, 32'h22, 32'hFFFF_80F0);

        cyc(1'b1, 2'b10, 1'b0, 32'h04, 32'h1122_3344);
        mis("mis_half5", 2'b01, 32'h05);
        mis("mis_word6", 2'b10, 32'h06);
        lit("mis_unchanged", 2'b10, 1'b0, 32'h04, 32'h1122_3344);
        mis("mis_size3", 2'b11, 32'h00);

        cyc(1'b1, 2'b00, 1'b0, 32'h30, 32'h0000_0011);
        cyc(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_0022);
        cyc(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_3344);
        lit("lanes_30", 2'b10, 1'b0, 32'h30, 32'h3344_2211);

        cyc(1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFE_F00D);
        lit("wrap_0", 2'b10, 1'b0, 32'h000, 32'hCAFE_F00D);

        for (int i = 0; i < 3000; i++) rnd_cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
